uart_oversample_counter: RTL

//  Parametrised oversampling bit timer for the UART receiver. Counts baud-rate ticks per bit, strobes the mid-bit sample point,

---
 rtl/uart_oversample_counter_pkg.sv | 12 +
 rtl/uart_oversample_counter_majority_vote3.sv | 11 +
 rtl/uart_oversample_counter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/uart_oversample_counter_pkg.sv
// Shared types and default sizing for the UART receive bit timer.
package uart_oversample_counter_pkg;

    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_NUM_BITS   = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/uart_oversample_counter_majority_vote3.sv
// Three-input combinational majority vote, shared by the RX sampling paths.
module majority_vote3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/uart_oversample_counter.sv
// Oversampling bit timer: counts baud ticks per bit, votes samples around mid-bit
// and tracks the bit position within a frame.
module uart_oversample_counter
    import uart_oversample_counter_pkg::*;
#(
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int NUM_BITS   = DEF_NUM_BITS,
    parameter int MAJORITY   = 1,
    localparam int CNT_W     = $clog2(OVERSAMPLE),
    localparam int BIT_W     = $clog2(NUM_BITS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             clear,
    input  logic             tick_en,
    input  logic             rx_in,
    output logic             busy,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [BIT_W-1:0] bit_index,
    output logic             sample_strobe,
    output logic             bit_done,
    output logic             bit_value,
    output logic             frame_done,
    output state_t           state_dbg
);

    localparam int MID = OVERSAMPLE / 2;
    localparam logic [CNT_W-1:0] MID_M1   = CNT_W'(MID - 1);
    localparam logic [CNT_W-1:0] MID_C    = CNT_W'(MID);
    localparam logic [CNT_W-1:0] MID_P1   = CNT_W'(MID + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] IDX_LAST = BIT_W'(NUM_BITS - 1);

    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4 || NUM_BITS < 1) begin : g_param_check
        $error("uart_oversample_counter: OVERSAMPLE must be even and >= 4, NUM_BITS >= 1");
    end

    // start, clear and tick_en are single-cycle pulses with no backpressure; clear beats start beats tick_en.
    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [BIT_W-1:0] idx_nxt;
    logic [2:0]       samp, samp_cap, samp_nxt;
    logic             strobe_nxt, done_nxt, value_nxt, frame_nxt;
    logic             vote3, voted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            sample_cnt    <= '0;
            bit_index     <= '0;
            samp          <= '0;
            sample_strobe <= 1'b0;
            bit_done      <= 1'b0;
            bit_value     <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            state         <= state_nxt;
            sample_cnt    <= cnt_nxt;
            bit_index     <= idx_nxt;
            samp          <= samp_nxt;
            sample_strobe <= strobe_nxt;
            bit_done      <= done_nxt;
            bit_value     <= value_nxt;
            frame_done    <= frame_nxt;
        end
    end

    // Samples including this tick's capture, so the vote sees MID+1 even when it lands on the last tick.
    always_comb begin
        samp_cap = samp;
        if (state == ST_RUN && tick_en && !clear) begin
            if (MAJORITY != 0) begin
                if (sample_cnt == MID_M1) samp_cap[0] = rx_in;
                if (sample_cnt == MID_C)  samp_cap[1] = rx_in;
                if (sample_cnt == MID_P1) samp_cap[2] = rx_in;
            end else if (sample_cnt == MID_C) begin
                samp_cap[1] = rx_in;
            end
        end
    end

    majority_vote3 u_vote (
        .a (samp_cap[0]),
        .b (samp_cap[1]),
        .c (samp_cap[2]),
        .y (vote3)
    );

    assign voted = (MAJORITY != 0) ? vote3 : samp_cap[1];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = sample_cnt;
        idx_nxt    = bit_index;
        samp_nxt   = samp_cap;
        strobe_nxt = 1'b0;
        done_nxt   = 1'b0;
        value_nxt  = bit_value;
        frame_nxt  = 1'b0;
        if (clear) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            idx_nxt   = '0;
            samp_nxt  = '0;
        end else if (state == ST_IDLE) begin
            cnt_nxt  = '0;
            idx_nxt  = '0;
            samp_nxt = '0;
            if (start) state_nxt = ST_RUN;
        end else if (tick_en) begin
            strobe_nxt = (sample_cnt == MID_C);
            if (sample_cnt == CNT_LAST) begin
                cnt_nxt   = '0;
                done_nxt  = 1'b1;
                value_nxt = voted;
                samp_nxt  = '0;
                if (bit_index == IDX_LAST) begin
                    idx_nxt   = '0;
                    frame_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    idx_nxt = bit_index + 1'b1;
                end
            end else begin
                cnt_nxt = sample_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        busy      = (state == ST_RUN);
        state_dbg = state;
    end

endmodule
